// File: rtl/cpu_mem_port.sv
// cpu_mem_port: single-ported big-endian word memory with valid/ready request and response.
// Latency: response valid LATENCY+1 cycles after the accepting edge; one transaction in flight.
// Backpressure: req_ready low from accept until the cycle after the response handshake.
// Optional feature: define MEM_SWAP_EN to enable atomic word swap (req_swap with req_write=0).
module cpu_mem_port #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_swap,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic        execute;
  logic [3:0]  cnt;

  logic        write_q;
  logic        byte_q;
  logic        swap_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        cur_write;
  logic        cur_byte;
  logic        cur_swap;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        swap_op;
  logic        in_range;
  logic        misalign;
  logic        fault;
  logic [AW-1:0] mem_idx;
  logic [31:0] old_word;
  logic [4:0]  lane_sh;
  logic [7:0]  lane_byte;
  logic [31:0] merged;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] rd_val;

  assign accept     = req_valid && (state == IDLE);
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // With zero latency the access executes on the accepting edge, so it must
  // see the live request fields rather than the latched copy.
  assign cur_write = (state == IDLE) ? req_write : write_q;
  assign cur_byte  = (state == IDLE) ? req_byte  : byte_q;
  assign cur_swap  = (state == IDLE) ? req_swap  : swap_q;
  assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;

`ifdef MEM_SWAP_EN
  assign swap_op = cur_swap & ~cur_write;
`else
  logic unused_swap;
  assign unused_swap = cur_swap;
  assign swap_op     = 1'b0;
`endif

  // Address decode: swaps obey word alignment; a byte swap is never legal.
  assign in_range = ({2'b00, cur_addr[31:2]} < 32'(DEPTH_WORDS));
  assign misalign = (cur_addr[1:0] != 2'b00) && (!cur_byte || swap_op);
  assign fault    = !in_range || misalign || (swap_op && cur_byte);
  assign mem_idx  = cur_addr[AW+1:2];
  assign old_word = mem[mem_idx];

  // Big-endian lanes: offset 0 is the most significant byte.
  assign lane_sh   = {~cur_addr[1:0], 3'b000};
  assign lane_byte = 8'(old_word >> lane_sh);
  assign merged    = (old_word & ~(32'h0000_00FF << lane_sh))
                   | (32'(cur_wdata[7:0]) << lane_sh);

  assign mem_we = execute && !fault && (cur_write || swap_op);
  assign mem_wd = (cur_byte && cur_write) ? merged : cur_wdata;
  assign rd_val = (fault || cur_write)     ? 32'h0 :
                  (cur_byte && !swap_op)   ? {24'h0, lane_byte} : old_word;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic and the single-cycle execute strobe.
  always_comb begin
    state_next = state;
    execute    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_next = RESP;
            execute    = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
          execute    = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= 4'd0;
      write_q    <= 1'b0;
      byte_q     <= 1'b0;
      swap_q     <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        byte_q  <= req_byte;
        swap_q  <= req_swap;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= LAT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (execute) begin
        resp_rdata <= rd_val;
        resp_err   <= fault;
      end
    end
  end

  // Storage is not reset; a reset edge must never commit an in-flight store.
  always_ff @(posedge clock) begin
    if (reset_n && mem_we) mem[mem_idx] <= mem_wd;
  end

endmodule

// File: tb/tb_cpu_mem_port.sv
// tb_cpu_mem_port: directed bench for cpu_mem_port at LATENCY 2, 0 and 15.
// Latency: measured per access from the accepting edge to resp_valid.
// Backpressure: exercises resp_ready held low and a request held across a response.
module tb_cpu_mem_port;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic        req_swap = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;

  logic [2:0]        vld = 3'b000;
  logic [2:0]        rrdy = 3'b000;
  logic [2:0]        rdy_v;
  logic [2:0]        rv_v;
  logic [2:0]        err_v;
  logic [2:0][31:0]  rdata_v;

  int n_checks = 0;
  int n_errors = 0;
  int exp_lat[3] = '{3, 1, 16};

  always #5 clock = ~clock;

  cpu_mem_port #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(vld[0]), .req_ready(rdy_v[0]),
    .req_write(req_write), .req_byte(req_byte), .req_swap(req_swap),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_v[0]), .resp_ready(rrdy[0]),
    .resp_rdata(rdata_v[0]), .resp_err(err_v[0])
  );

  cpu_mem_port #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut_l0 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(vld[1]), .req_ready(rdy_v[1]),
    .req_write(req_write), .req_byte(req_byte), .req_swap(req_swap),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_v[1]), .resp_ready(rrdy[1]),
    .resp_rdata(rdata_v[1]), .resp_err(err_v[1])
  );

  cpu_mem_port #(.DEPTH_WORDS(1024), .LATENCY(15)) u_dut_l15 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(vld[2]), .req_ready(rdy_v[2]),
    .req_write(req_write), .req_byte(req_byte), .req_swap(req_swap),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_v[2]), .resp_ready(rrdy[2]),
    .resp_rdata(rdata_v[2]), .resp_err(err_v[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction on instance sel; lat counts cycles from accept to resp_valid.
  task automatic access(input int sel, input logic w, input logic b, input logic s,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    int g;
    @(negedge clock);
    req_write = w; req_byte = b; req_swap = s; req_addr = a; req_wdata = d;
    vld[sel] = 1'b1; rrdy[sel] = 1'b1;
    g = 0;
    while (!rdy_v[sel] && g < 50) begin
      @(negedge clock);
      g++;
    end
    @(posedge clock);
    #1 vld[sel] = 1'b0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!rv_v[sel] && lat < 40);
    rd = rdata_v[sel];
    er = err_v[sel];
  endtask

  task automatic wr(input int sel, input logic b, input logic [31:0] a, input logic [31:0] d,
                    input logic ee, input string tag);
    logic [31:0] r;
    logic        e;
    int          l;
    access(sel, 1'b1, b, 1'b0, a, d, r, e, l);
    check({tag, ".err"}, 32'(e), 32'(ee));
    check({tag, ".lat"}, 32'(l), 32'(exp_lat[sel]));
  endtask

  task automatic rd(input int sel, input logic b, input logic [31:0] a,
                    input logic [31:0] ed, input logic ee, input string tag);
    logic [31:0] r;
    logic        e;
    int          l;
    access(sel, 1'b0, b, 1'b0, a, 32'h0, r, e, l);
    check({tag, ".data"}, r, ed);
    check({tag, ".err"}, 32'(e), 32'(ee));
    check({tag, ".lat"}, 32'(l), 32'(exp_lat[sel]));
  endtask

  // Directed sequence.
  initial begin
    logic [31:0] r;
    logic        e;
    int          l;
    int          g;

    #3 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("rst.req_ready", 32'(rdy_v[0]), 32'd1);
    check("rst.resp_valid", 32'(rv_v[0]), 32'd0);
    check("rst.resp_rdata", rdata_v[0], 32'h0);
    check("rst.resp_err", 32'(err_v[0]), 32'd0);
    reset_n = 1'b1;

    // Basic word store / load.
    wr(0, 1'b0, 32'h8, 32'h2008_0007, 1'b0, "sw8");
    rd(0, 1'b0, 32'h8, 32'h2008_0007, 1'b0, "lw8");

    // Byte lanes, big-endian.
    wr(0, 1'b0, 32'h50, 32'hAABB_CCDD, 1'b0, "sw50");
    wr(0, 1'b1, 32'h52, 32'h0000_0011, 1'b0, "sb52");
    rd(0, 1'b0, 32'h50, 32'hAABB_11DD, 1'b0, "lw50");
    rd(0, 1'b1, 32'h51, 32'h0000_00BB, 1'b0, "lb51");
    rd(0, 1'b1, 32'h53, 32'h0000_00DD, 1'b0, "lb53");

    // Faults: misalignment and out-of-range, with no side effects.
    wr(0, 1'b0, 32'h78, 32'h0102_0304, 1'b0, "sw78");
    rd(0, 1'b0, 32'h7A, 32'h0, 1'b1, "lw7a");
    wr(0, 1'b0, 32'h7A, 32'hDEAD_BEEF, 1'b1, "sw7a");
    rd(0, 1'b0, 32'h78, 32'h0102_0304, 1'b0, "lw78");
    wr(0, 1'b0, 32'h0, 32'h1111_2222, 1'b0, "sw0");
    rd(0, 1'b0, 32'd4096, 32'h0, 1'b1, "lw4096");
    wr(0, 1'b0, 32'd4096, 32'h9999_9999, 1'b1, "sw4096");
    rd(0, 1'b0, 32'h0, 32'h1111_2222, 1'b0, "lw0");
    wr(0, 1'b0, 32'hFFC, 32'h0A0B_0C0D, 1'b0, "swffc");
    rd(0, 1'b1, 32'hFFF, 32'h0000_000D, 1'b0, "lbfff");

    // Response backpressure with a second request waiting.
    @(negedge clock);
    req_write = 1'b0; req_byte = 1'b0; req_swap = 1'b0; req_addr = 32'h8;
    vld[0] = 1'b1; rrdy[0] = 1'b0;
    @(posedge clock);
    #1 req_addr = 32'h50;
    g = 0;
    do begin
      @(negedge clock);
      g++;
    end while (!rv_v[0] && g < 40);
    check("stall.lat", 32'(g), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("stall.valid", 32'(rv_v[0]), 32'd1);
      check("stall.rdata", rdata_v[0], 32'h2008_0007);
      check("stall.ready", 32'(rdy_v[0]), 32'd0);
      @(negedge clock);
    end
    rrdy[0] = 1'b1;
    @(negedge clock);
    check("hs.valid", 32'(rv_v[0]), 32'd0);
    check("hs.ready", 32'(rdy_v[0]), 32'd1);
    @(negedge clock);
    check("second.accepted", 32'(rdy_v[0]), 32'd0);
    vld[0] = 1'b0;
    g = 0;
    while (!rv_v[0] && g < 40) begin
      @(negedge clock);
      g++;
    end
    check("second.rdata", rdata_v[0], 32'hAABB_11DD);

    // Latency extremes.
    wr(1, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b0, "l0.sw");
    rd(1, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b0, "l0.lw");
    rd(1, 1'b1, 32'h22, 32'h0000_00F0, 1'b0, "l0.lb");
    wr(2, 1'b0, 32'h20, 32'h0BAD_F00D, 1'b0, "l15.sw");
    rd(2, 1'b0, 32'h20, 32'h0BAD_F00D, 1'b0, "l15.lw");

    // Reset during WAIT aborts the store; earlier commits survive.
    wr(0, 1'b0, 32'h10, 32'h55AA_55AA, 1'b0, "sw10");
    @(negedge clock);
    req_write = 1'b1; req_byte = 1'b0; req_swap = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h1234_5678;
    vld[0] = 1'b1; rrdy[0] = 1'b1;
    @(posedge clock);
    #1 vld[0] = 1'b0;
    @(negedge clock);
    check("wait.ready", 32'(rdy_v[0]), 32'd0);
    reset_n = 1'b0;
    #1;
    check("rstw.req_ready", 32'(rdy_v[0]), 32'd1);
    check("rstw.resp_valid", 32'(rv_v[0]), 32'd0);
    check("rstw.resp_rdata", rdata_v[0], 32'h0);
    check("rstw.resp_err", 32'(err_v[0]), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    rd(0, 1'b0, 32'h10, 32'h55AA_55AA, 1'b0, "lw10");
    rd(0, 1'b0, 32'h8, 32'h2008_0007, 1'b0, "lw8.kept");

    // Swap, or a plain read when the feature is compiled out.
    wr(0, 1'b0, 32'h78, 32'h0000_0005, 1'b0, "sw78b");
    access(0, 1'b0, 1'b0, 1'b1, 32'h78, 32'h0000_000C, r, e, l);
    check("swap.rdata", r, 32'h0000_0005);
    check("swap.err", 32'(e), 32'd0);
`ifdef MEM_SWAP_EN
    rd(0, 1'b0, 32'h78, 32'h0000_000C, 1'b0, "swap.mem");
    access(0, 1'b0, 1'b1, 1'b1, 32'h78, 32'h0000_0077, r, e, l);
    check("swapb.err", 32'(e), 32'd1);
    rd(0, 1'b0, 32'h78, 32'h0000_000C, 1'b0, "swapb.mem");
`else
    rd(0, 1'b0, 32'h78, 32'h0000_0005, 1'b0, "swap.mem");
`endif

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog so a stuck handshake cannot hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
